// File: rtl/dcr_shadow_bank_pkg.sv
// ==========================================================================
// dcr_shadow_bank_pkg - shared DCR constants, commit FSM states, range check
// Revision: 1.0
// ==========================================================================
`default_nettype none

package dcr_shadow_bank_pkg;

  localparam logic [11:0] DCR_BASE_ADDR = 12'h001;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COPY    = 2'd2
  } dcr_bank_state_e;

  // idx is (addr - base) already wrapped to the bus address width
  function automatic logic dcr_in_range(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] idx,
                                        input int unsigned num_regs);
    return (addr >= base) && (idx < num_regs);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dcr_byte_reg.sv
// ==========================================================================
// dcr_byte_reg - one DATA_W register with per-byte write enables
// Revision: 1.0
// ==========================================================================
`default_nettype none

module dcr_byte_reg #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   d,
  output logic [DATA_W-1:0]   q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RESET_VAL;
    end else if (we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (be[b]) q[b*8 +: 8] <= d[b*8 +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dcr_shadow_bank.sv
// ==========================================================================
// dcr_shadow_bank - shadow/active DCR bank with atomic, idle-gated commit
// Revision: 1.0
// ==========================================================================
`default_nettype none

module dcr_shadow_bank
  import dcr_shadow_bank_pkg::*;
#(
  parameter int                         NUM_REGS   = 8,
  parameter int                         DATA_W     = 32,
  parameter int                         ADDR_W     = 12,
  parameter logic [ADDR_W-1:0]          BASE_ADDR  = ADDR_W'(DCR_BASE_ADDR),
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALS = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_valid,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W/8-1:0]        wr_byteen,
  input  logic                       rd_valid,
  input  logic [ADDR_W-1:0]          rd_addr,
  input  logic                       rd_shadow,
  output logic                       rd_rsp_valid,
  output logic [DATA_W-1:0]          rd_rsp_data,
  output logic                       rd_rsp_err,
  input  logic                       commit_valid,
  output logic                       commit_ready,
  input  logic                       cores_busy,
  output logic                       commit_done,
  output logic [NUM_REGS-1:0]        dirty,
  output logic [NUM_REGS*DATA_W-1:0] active_dcrs
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  dcr_bank_state_e   state;
  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W-1:0] rd_idx;
  logic              wr_hit;
  logic              rd_hit;
  logic              copy_en;
  logic [NUM_REGS-1:0] wr_sel;
  logic [DATA_W-1:0] shadow_q [NUM_REGS];
  logic [DATA_W-1:0] active_q [NUM_REGS];

  assign wr_idx  = wr_addr - BASE_ADDR;
  assign rd_idx  = rd_addr - BASE_ADDR;
  assign wr_hit  = wr_valid &&
                   dcr_in_range(32'(wr_addr), 32'(BASE_ADDR), 32'(wr_idx), unsigned'(NUM_REGS));
  assign rd_hit  = dcr_in_range(32'(rd_addr), 32'(BASE_ADDR), 32'(rd_idx), unsigned'(NUM_REGS));
  assign copy_en = (state == COPY);
  assign commit_ready = (state == IDLE);

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
      assign wr_sel[i] = wr_hit && (wr_idx == ADDR_W'(i));

      dcr_byte_reg #(
        .DATA_W    (DATA_W),
        .RESET_VAL (RESET_VALS[i*DATA_W +: DATA_W])
      ) u_shadow (
        .clk   (clk),
        .reset (reset),
        .we    (wr_sel[i]),
        .be    (wr_byteen),
        .d     (wr_data),
        .q     (shadow_q[i])
      );

      // Active copy takes the pre-edge shadow, so a write landing in the
      // COPY cycle stays in the shadow only.
      dcr_byte_reg #(
        .DATA_W    (DATA_W),
        .RESET_VAL (RESET_VALS[i*DATA_W +: DATA_W])
      ) u_active (
        .clk   (clk),
        .reset (reset),
        .we    (copy_en),
        .be    ({(DATA_W/8){1'b1}}),
        .d     (shadow_q[i]),
        .q     (active_q[i])
      );

      assign active_dcrs[i*DATA_W +: DATA_W] = active_q[i];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      commit_done <= 1'b0;
      dirty       <= '0;
    end else begin
      commit_done <= 1'b0;
      dirty       <= (copy_en ? '0 : dirty) | wr_sel;
      case (state)
        IDLE:    if (commit_valid) state <= cores_busy ? PENDING : COPY;
        PENDING: if (!cores_busy) state <= COPY;
        COPY: begin
          state       <= IDLE;
          commit_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_rsp_valid <= 1'b0;
      rd_rsp_data  <= '0;
      rd_rsp_err   <= 1'b0;
    end else begin
      rd_rsp_valid <= rd_valid;
      if (rd_valid) begin
        if (rd_hit) begin
          rd_rsp_data <= rd_shadow ? shadow_q[rd_idx[IDX_W-1:0]]
                                   : active_q[rd_idx[IDX_W-1:0]];
          rd_rsp_err  <= 1'b0;
        end else begin
          rd_rsp_data <= '0;
          rd_rsp_err  <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dcr_shadow_bank.sv
// ==========================================================================
// tb_dcr_shadow_bank - randomized bench against a behavioural bank model
// Revision: 1.0
// ==========================================================================
`default_nettype none

module tb_dcr_shadow_bank;

  localparam int         NREG = 8;
  localparam int         BASE = 1;
  localparam logic [255:0] RVALS = {224'b0, 32'h8000_0000};

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         wr_valid = 1'b0;
  logic [11:0]  wr_addr = '0;
  logic [31:0]  wr_data = '0;
  logic [3:0]   wr_byteen = '0;
  logic         rd_valid = 1'b0;
  logic [11:0]  rd_addr = '0;
  logic         rd_shadow = 1'b0;
  logic         rd_rsp_valid;
  logic [31:0]  rd_rsp_data;
  logic         rd_rsp_err;
  logic         commit_valid = 1'b0;
  logic         commit_ready;
  logic         cores_busy = 1'b0;
  logic         commit_done;
  logic [7:0]   dirty;
  logic [255:0] active_dcrs;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model of the bank
  logic [31:0] sh [NREG];
  logic [31:0] ac [NREG];
  logic [7:0]  m_dirty;
  bit          waiting_for_idle;
  bit          copy_now;
  logic        e_valid, e_err, e_done;
  logic [31:0] e_data;

  always #5 clk = ~clk;

  dcr_shadow_bank #(
    .NUM_REGS   (NREG),
    .DATA_W     (32),
    .ADDR_W     (12),
    .BASE_ADDR  (12'h001),
    .RESET_VALS (RVALS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_byteen    (wr_byteen),
    .rd_valid     (rd_valid),
    .rd_addr      (rd_addr),
    .rd_shadow    (rd_shadow),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_data  (rd_rsp_data),
    .rd_rsp_err   (rd_rsp_err),
    .commit_valid (commit_valid),
    .commit_ready (commit_ready),
    .cores_busy   (cores_busy),
    .commit_done  (commit_done),
    .dirty        (dirty),
    .active_dcrs  (active_dcrs)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] model_active();
    logic [255:0] v;
    for (int i = 0; i < NREG; i++) v[i*32 +: 32] = ac[i];
    return v;
  endfunction

  function automatic int reg_index(input logic [11:0] a);
    if (int'(a) >= BASE && int'(a) < BASE + NREG) return int'(a) - BASE;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      sh[i] = RVALS[i*32 +: 32];
      ac[i] = RVALS[i*32 +: 32];
    end
    m_dirty = '0;
    waiting_for_idle = 0;
    copy_now = 0;
    e_valid = 0; e_err = 0; e_done = 0; e_data = '0;
  endtask

  task automatic check_outputs();
    check("rd_rsp_valid", 256'(rd_rsp_valid), 256'(e_valid));
    if (e_valid) begin
      check("rd_rsp_data", 256'(rd_rsp_data), 256'(e_data));
      check("rd_rsp_err", 256'(rd_rsp_err), 256'(e_err));
    end
    check("commit_done", 256'(commit_done), 256'(e_done));
    check("dirty", 256'(dirty), 256'(m_dirty));
    check("active_dcrs", active_dcrs, model_active());
  endtask

  // one clock: model consumes the current inputs, DUT sees the same edge
  task automatic cyc();
    int wi, ri;
    check("commit_ready", 256'(commit_ready), 256'(!waiting_for_idle && !copy_now));
    e_valid = rd_valid;
    if (rd_valid) begin
      ri = reg_index(rd_addr);
      if (ri >= 0) begin
        e_data = rd_shadow ? sh[ri] : ac[ri];
        e_err  = 0;
      end else begin
        e_data = '0;
        e_err  = 1;
      end
    end
    e_done = copy_now;
    if (copy_now) begin
      for (int i = 0; i < NREG; i++) ac[i] = sh[i];
      m_dirty = '0;
    end
    wi = reg_index(wr_addr);
    if (wr_valid && wi >= 0) begin
      for (int b = 0; b < 4; b++)
        if (wr_byteen[b]) sh[wi][b*8 +: 8] = wr_data[b*8 +: 8];
      m_dirty[wi] = 1'b1;
    end
    if (copy_now) begin
      copy_now = 0;
    end else if (waiting_for_idle) begin
      if (!cores_busy) begin
        waiting_for_idle = 0;
        copy_now = 1;
      end
    end else if (commit_valid) begin
      if (cores_busy) waiting_for_idle = 1;
      else copy_now = 1;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic quiet();
    wr_valid = 0; rd_valid = 0; commit_valid = 0;
  endtask

  task automatic do_write(input int a, input logic [31:0] d, input logic [3:0] be);
    wr_valid = 1; wr_addr = 12'(a); wr_data = d; wr_byteen = be;
  endtask

  task automatic do_read(input int a, input logic shadow);
    rd_valid = 1; rd_addr = 12'(a); rd_shadow = shadow;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_active", active_dcrs, RVALS);
    check("reset_dirty", 256'(dirty), 256'(0));
    check("reset_ready", 256'(commit_ready), 256'(1));
    check_outputs();
    reset = 1;

    // partial-byte write, then shadow and active read-back
    quiet(); do_write(BASE + 2, 32'hDEAD_BEEF, 4'b0011); cyc();
    quiet(); do_read(BASE + 2, 1); cyc();
    check("shadow_rd2", 256'(rd_rsp_data), 256'(32'h0000_BEEF));
    quiet(); do_read(BASE + 2, 0); cyc();
    check("active_rd2", 256'(rd_rsp_data), 256'(0));

    // commit with cores idle
    quiet(); commit_valid = 1; cores_busy = 0; cyc();
    quiet(); cyc();
    check("done_lat2", 256'(commit_done), 256'(1));
    check("active_reg2", 256'(active_dcrs[95:64]), 256'(32'h0000_BEEF));
    quiet(); cyc();

    // commit deferred by busy cores, write during the wait
    quiet(); commit_valid = 1; cores_busy = 1; cyc();
    for (int k = 0; k < 5; k++) begin
      quiet();
      if (k == 2) do_write(BASE + 1, 32'h0000_1234, 4'hF);
      cyc();
    end
    quiet(); cores_busy = 0;
    for (int k = 0; k < 3; k++) cyc();
    check("active_reg1", 256'(active_dcrs[63:32]), 256'(32'h0000_1234));

    // write landing in the COPY cycle
    quiet(); commit_valid = 1; cyc();
    quiet(); do_write(BASE + 3, 32'hCAFE_0003, 4'hF); cyc();
    quiet(); cyc();
    check("copy_cycle_dirty3", 256'(dirty[3]), 256'(1));
    check("copy_cycle_active3", 256'(active_dcrs[127:96]), 256'(0));

    // out-of-range access
    quiet(); do_write(BASE + NREG, 32'hFFFF_FFFF, 4'hF); do_read(BASE + NREG, 1); cyc();
    check("oor_err", 256'(rd_rsp_err), 256'(1));

    // async reset while PENDING
    quiet(); commit_valid = 1; cores_busy = 1; cyc();
    quiet(); cyc();
    #2 reset = 0;
    #1;
    model_reset();
    check("arst_active", active_dcrs, RVALS);
    check("arst_dirty", 256'(dirty), 256'(0));
    check("arst_ready", 256'(commit_ready), 256'(1));
    check_outputs();
    @(posedge clk); #2 reset = 1;
    cores_busy = 0;
    #1;
    for (int k = 0; k < 4; k++) cyc();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      wr_valid     = ($urandom_range(0, 1) == 1);
      wr_addr      = ($urandom_range(0, 15) == 0) ? 12'hFFF : 12'($urandom_range(0, 11));
      wr_data      = $urandom;
      wr_byteen    = 4'($urandom_range(0, 15));
      rd_valid     = ($urandom_range(0, 1) == 1);
      rd_addr      = ($urandom_range(0, 15) == 0) ? 12'hFFF : 12'($urandom_range(0, 11));
      rd_shadow    = 1'($urandom_range(0, 1));
      commit_valid = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 5) == 0) cores_busy = ~cores_busy;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
